// File: rtl/i2c_master_core.sv
// Byte-level I2C initiator: executes one START / WRITE / READ / STOP command at a time,
// with quarter-period bit timing and SCL clock-stretching support.
module i2c_master_core #(
   parameter int unsigned CLK_DIV = 62
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_data,
   input  logic       tx_nack,
   output logic       rsp_valid,
   output logic [7:0] rx_data,
   output logic       rx_ack,
   output logic       bus_owned,
   output logic       scl_o,
   output logic       sda_o,
   input  logic       scl_i,
   input  logic       sda_i
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   localparam logic [1:0] CmdStart = 2'd0;
   localparam logic [1:0] CmdWrite = 2'd1;
   localparam logic [1:0] CmdRead  = 2'd2;
   localparam logic [1:0] CmdStop  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBit,
      StAckBit,
      StStop,
      StReject
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      q_q, q_d;
   logic [DivW-1:0] div_q, div_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [7:0]      tx_q, tx_d;
   logic            nack_q, nack_d;
   logic [7:0]      shift_q, shift_d;
   logic            scl_q, scl_d;
   logic            sda_q, sda_d;
   logic            rsp_q, rsp_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_ack_q, rx_ack_d;
   logic            owned_q, owned_d;

   logic busy;
   logic q_end;
   logic stall;
   logic sample;
   logic reject_cmd;

   assign busy       = (state_q == StStart) || (state_q == StBit) ||
                       (state_q == StAckBit) || (state_q == StStop);
   assign q_end      = (div_q == DivLast);
   // A slave holding SCL low freezes the divider at the start of q2.
   assign stall      = (q_q == 2'd2) && (div_q == '0) && !scl_i;
   assign sample     = (q_q == 2'd2) && q_end;
   assign reject_cmd = (cmd != CmdStart) && !owned_q;

   // Next-state, line levels and response generation.
   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      div_d     = div_q;
      bit_d     = bit_q;
      cmd_d     = cmd_q;
      tx_d      = tx_q;
      nack_d    = nack_q;
      shift_d   = shift_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      rsp_d     = 1'b0;
      rx_data_d = rx_data_q;
      rx_ack_d  = rx_ack_q;
      owned_d   = owned_q;

      if (busy && !stall) begin
         if (q_end) begin
            div_d = '0;
            q_d   = q_q + 2'd1;
         end else begin
            div_d = div_q + DivW'(1);
         end
      end

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               cmd_d  = cmd;
               nack_d = tx_nack;
               div_d  = '0;
               q_d    = 2'd0;
               bit_d  = 3'd0;
               // READ shifts out all-ones so SDA stays released during its data bits.
               tx_d   = (cmd == CmdRead) ? 8'hFF : tx_data;
               if (reject_cmd) begin
                  state_d  = StReject;
                  rsp_d    = 1'b1;
                  rx_ack_d = 1'b1;
               end else begin
                  case (cmd)
                     CmdStart: begin
                        state_d = StStart;
                        sda_d   = 1'b1;
                     end
                     CmdWrite, CmdRead: begin
                        state_d = StBit;
                        scl_d   = 1'b0;
                        sda_d   = (cmd == CmdRead) ? 1'b1 : tx_data[7];
                     end
                     default: begin
                        state_d = StStop;
                        scl_d   = 1'b0;
                        sda_d   = 1'b0;
                     end
                  endcase
               end
            end
         end

         StReject: state_d = StIdle;

         StStart: begin
            if (q_end) begin
               case (q_q)
                  2'd0: scl_d = 1'b1;
                  2'd1: sda_d = 1'b0;
                  2'd2: scl_d = 1'b0;
                  default: begin
                     state_d = StIdle;
                     rsp_d   = 1'b1;
                     owned_d = 1'b1;
                  end
               endcase
            end
         end

         StBit: begin
            if (sample && (cmd_q == CmdRead)) begin
               shift_d = {shift_q[6:0], sda_i};
            end
            if (q_end) begin
               case (q_q)
                  2'd1: scl_d = 1'b1;
                  2'd3: begin
                     scl_d = 1'b0;
                     if (bit_q == 3'd7) begin
                        state_d = StAckBit;
                        sda_d   = (cmd_q == CmdRead) ? nack_q : 1'b1;
                     end else begin
                        bit_d = bit_q + 3'd1;
                        sda_d = tx_q[6];
                        tx_d  = {tx_q[6:0], 1'b1};
                     end
                  end
                  default: ;
               endcase
            end
         end

         StAckBit: begin
            if (sample && (cmd_q == CmdWrite)) begin
               rx_ack_d = sda_i;
            end
            if (q_end) begin
               case (q_q)
                  2'd1: scl_d = 1'b1;
                  2'd3: begin
                     scl_d   = 1'b0;
                     state_d = StIdle;
                     rsp_d   = 1'b1;
                     if (cmd_q == CmdRead) begin
                        rx_data_d = shift_q;
                     end
                  end
                  default: ;
               endcase
            end
         end

         StStop: begin
            if (q_end) begin
               case (q_q)
                  2'd0: scl_d = 1'b1;
                  2'd1: sda_d = 1'b1;
                  2'd3: begin
                     state_d = StIdle;
                     rsp_d   = 1'b1;
                     owned_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State register; reset releases both lines without generating a STOP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         q_q       <= 2'd0;
         div_q     <= '0;
         bit_q     <= 3'd0;
         cmd_q     <= 2'd0;
         tx_q      <= 8'h00;
         nack_q    <= 1'b0;
         shift_q   <= 8'h00;
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
         rsp_q     <= 1'b0;
         rx_data_q <= 8'h00;
         rx_ack_q  <= 1'b0;
         owned_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         cmd_q     <= cmd_d;
         tx_q      <= tx_d;
         nack_q    <= nack_d;
         shift_q   <= shift_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         rsp_q     <= rsp_d;
         rx_data_q <= rx_data_d;
         rx_ack_q  <= rx_ack_d;
         owned_q   <= owned_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = rsp_q;
   assign rx_data   = rx_data_q;
   assign rx_ack    = rx_ack_q;
   assign bus_owned = owned_q;
   assign scl_o     = scl_q;
   assign sda_o     = sda_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with a small SHT31-style responder at address 0x44.
module tb_i2c_master_core;

   localparam int unsigned D = 4;
   localparam logic [1:0] CStart = 2'd0;
   localparam logic [1:0] CWrite = 2'd1;
   localparam logic [1:0] CRead  = 2'd2;
   localparam logic [1:0] CStop  = 2'd3;
   localparam logic [7:0] Rd0 = 8'h66;
   localparam logic [7:0] Rd1 = 8'h5A;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd;
   logic [7:0] tx_data;
   logic       tx_nack;
   logic       rsp_valid;
   logic [7:0] rx_data;
   logic       rx_ack;
   logic       bus_owned;
   logic       scl_o;
   logic       sda_o;
   logic       scl_line;
   logic       sda_line;
   logic       stretch;
   logic       in_xfer;

   int n_checks = 0;
   int n_pass   = 0;

   // Responder / monitor state.
   logic       s_sda      = 1'b1;
   logic       p_scl      = 1'b1;
   logic       p_sda      = 1'b1;
   logic [1:0] sl_mode    = 2'd0;
   logic [3:0] sl_cnt     = 4'd0;
   logic [7:0] sl_shift   = 8'h00;
   logic [7:0] sl_byte    = 8'h00;
   logic [7:0] sl_last_rx = 8'h00;
   logic       sl_addr_ph = 1'b0;
   logic       sl_read    = 1'b0;
   logic       sl_mnack   = 1'b0;
   int         sl_idx     = 0;
   logic       last9      = 1'b1;
   int         viol_cnt   = 0;
   int         low_cnt    = 0;

   assign scl_line = scl_o & ~stretch;
   assign sda_line = sda_o & s_sda;

   always #5 clk = ~clk;

   i2c_master_core #(.CLK_DIV(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .tx_data   (tx_data),
      .tx_nack   (tx_nack),
      .rsp_valid (rsp_valid),
      .rx_data   (rx_data),
      .rx_ack    (rx_ack),
      .bus_owned (bus_owned),
      .scl_o     (scl_o),
      .sda_o     (sda_o),
      .scl_i     (scl_line),
      .sda_i     (sda_line)
   );

   // Responder model, sampled mid-cycle so simultaneous SCL/SDA edges are never mistaken
   // for START/STOP.
   always @(negedge clk) begin
      p_scl <= scl_line;
      p_sda <= sda_line;
      if (!scl_o || !sda_o) low_cnt <= low_cnt + 1;
      if (p_scl && scl_line && (p_sda != sda_line) && in_xfer) viol_cnt <= viol_cnt + 1;
      if (p_scl && scl_line && p_sda && !sda_line) begin
         sl_mode    <= 2'd1;
         sl_cnt     <= 4'd0;
         sl_addr_ph <= 1'b1;
         s_sda      <= 1'b1;
      end else if (p_scl && scl_line && !p_sda && sda_line) begin
         sl_mode <= 2'd0;
         s_sda   <= 1'b1;
      end else if (!p_scl && scl_line) begin
         last9 <= sda_line;
         if (sl_mode != 2'd0) begin
            if (sl_cnt < 4'd8 && sl_mode == 2'd1) sl_shift <= {sl_shift[6:0], sda_line};
            if (sl_cnt == 4'd8 && sl_mode == 2'd2) sl_mnack <= sda_line;
            sl_cnt <= sl_cnt + 4'd1;
         end
      end else if (p_scl && !scl_line && sl_mode != 2'd0) begin
         if (sl_mode == 2'd1) begin
            if (sl_cnt == 4'd8) begin
               sl_last_rx <= sl_shift;
               if (!sl_addr_ph || sl_shift[7:1] == 7'h44) begin
                  s_sda <= 1'b0;
                  if (sl_addr_ph) sl_read <= sl_shift[0];
               end else begin
                  s_sda   <= 1'b1;
                  sl_mode <= 2'd0;
               end
            end else if (sl_cnt == 4'd9) begin
               sl_cnt     <= 4'd0;
               sl_addr_ph <= 1'b0;
               if (sl_addr_ph && sl_read) begin
                  sl_mode <= 2'd2;
                  sl_byte <= Rd0;
                  sl_idx  <= 1;
                  s_sda   <= Rd0[7];
               end else begin
                  s_sda <= 1'b1;
               end
            end else begin
               s_sda <= 1'b1;
            end
         end else begin
            if (sl_cnt == 4'd9) begin
               sl_cnt <= 4'd0;
               if (sl_mnack) begin
                  sl_mode <= 2'd0;
                  s_sda   <= 1'b1;
               end else begin
                  sl_byte <= (sl_idx == 1) ? Rd1 : 8'h00;
                  s_sda   <= (sl_idx == 1) ? Rd1[7] : 1'b0;
                  sl_idx  <= sl_idx + 1;
               end
            end else if (sl_cnt == 4'd8) begin
               s_sda <= 1'b1;
            end else begin
               s_sda <= sl_byte[3'(7 - sl_cnt)];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Issue one command at a negedge with cmd_ready high and wait for its response.
   task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic n,
                         output int lat);
      cmd       = c;
      tx_data   = d;
      tx_nack   = n;
      cmd_valid = 1'b1;
      in_xfer   = (c == CWrite) || (c == CRead);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("ready_fall", cmd_ready, 1'b0);
      lat = 1;
      while (!rsp_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_seen", rsp_valid, 1'b1);
      in_xfer = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int l0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = 2'd0;
      tx_data   = 8'h00;
      tx_nack   = 1'b0;
      stretch   = 1'b0;
      in_xfer   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_scl", scl_o, 1'b1);
      check("rst_sda", sda_o, 1'b1);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_rsp", rsp_valid, 1'b0);
      check("rst_rxdata", rx_data, 8'h00);
      check("rst_rxack", rx_ack, 1'b0);
      check("rst_owned", bus_owned, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reject: READ without owning the bus.
      l0 = low_cnt;
      do_cmd(CRead, 8'h00, 1'b0, lat);
      check("rej_lat", lat, 1);
      check("rej_ack", rx_ack, 1'b1);
      check("rej_rxdata", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      check("rej_lines", low_cnt - l0, 0);
      check("rej_owned", bus_owned, 1'b0);

      // Address ACK.
      do_cmd(CStart, 8'h00, 1'b0, lat);
      check("start_lat", lat, 4 * D + 1);
      check("start_owned", bus_owned, 1'b1);
      do_cmd(CWrite, 8'h88, 1'b0, lat);
      check("wr88_lat", lat, 36 * D + 1);
      check("wr88_ack", rx_ack, 1'b0);
      do_cmd(CStop, 8'h00, 1'b0, lat);
      check("stop_lat", lat, 4 * D + 1);
      check("stop_owned", bus_owned, 1'b0);

      // Absent address.
      do_cmd(CStart, 8'h00, 1'b0, lat);
      do_cmd(CWrite, 8'h8A, 1'b0, lat);
      check("wr8a_ack", rx_ack, 1'b1);
      do_cmd(CStop, 8'h00, 1'b0, lat);
      check("stop2_scl", scl_o, 1'b1);
      check("stop2_sda", sda_o, 1'b1);
      check("stop2_owned", bus_owned, 1'b0);

      // Read sequence.
      do_cmd(CStart, 8'h00, 1'b0, lat);
      do_cmd(CWrite, 8'h89, 1'b0, lat);
      check("wr89_ack", rx_ack, 1'b0);
      do_cmd(CRead, 8'h00, 1'b0, lat);
      check("rd0_lat", lat, 36 * D + 1);
      check("rd0_data", rx_data, Rd0);
      check("rd0_ackbit", last9, 1'b0);
      do_cmd(CRead, 8'h00, 1'b1, lat);
      check("rd1_data", rx_data, Rd1);
      check("rd1_ackbit", last9, 1'b1);
      check("rd_rxack_kept", rx_ack, 1'b0);
      do_cmd(CStop, 8'h00, 1'b0, lat);
      check("sda_stable", viol_cnt, 0);

      // Clock stretching for 50 cycles in bit 3.
      do_cmd(CStart, 8'h00, 1'b0, lat);
      fork
         do_cmd(CWrite, 8'h88, 1'b0, lat);
         begin
            repeat (3) @(negedge scl_o);
            stretch = 1'b1;
            @(posedge scl_o);
            repeat (51) @(negedge clk);
            stretch = 1'b0;
         end
      join
      check("str_lat", lat, 36 * D + 1 + 50);
      check("str_ack", rx_ack, 1'b0);
      check("str_byte", sl_last_rx, 8'h88);
      do_cmd(CStop, 8'h00, 1'b0, lat);

      // Reset in bit 5 of a WRITE.
      do_cmd(CStart, 8'h00, 1'b0, lat);
      cmd       = CWrite;
      tx_data   = 8'h88;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (84) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_scl", scl_o, 1'b1);
      check("mrst_sda", sda_o, 1'b1);
      check("mrst_ready", cmd_ready, 1'b1);
      check("mrst_owned", bus_owned, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_cmd(CStart, 8'h00, 1'b0, lat);
      do_cmd(CWrite, 8'h88, 1'b0, lat);
      check("post_rst_lat", lat, 36 * D + 1);
      check("post_rst_ack", rx_ack, 1'b0);
      do_cmd(CStop, 8'h00, 1'b0, lat);
      check("final_stable", viol_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
